// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode encoding and sizing helpers for the counter front end
package counter_pkg;

    localparam logic MODE_STOPPED = 1'b0;
    localparam logic MODE_RUNNING = 1'b1;

    typedef enum logic {
        ST_STOPPED = MODE_STOPPED,
        ST_RUNNING = MODE_RUNNING
    } mode_e;

    function automatic int prescale_width(input int prescale);
        return ($clog2(prescale) < 1) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchroniser, debounce filter and press detector for one button
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            stable_d <= stable;
            // The flip happens on the edge that completes the run of differing samples.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = stable;
    assign press = stable & ~stable_d;

endmodule

// File: rtl/count_enable_gen.sv
// rtl/count_enable_gen.sv - step/free-run enable generator feeding the 4-bit counter
module count_enable_gen
    import counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PRESCALE        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_step,
    input  logic btn_run,
    output logic enable,
    output logic running
);

    localparam int PW = prescale_width(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic step_level;
    logic step_press;
    logic run_level;
    logic run_press;
    logic unused_levels;

    mode_e          state;
    mode_e          state_next;
    logic [PW-1:0]  prescale_cnt;
    logic [PW-1:0]  prescale_next;
    logic           enable_next;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_step),
        .level  (step_level),
        .press  (step_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_run (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_run),
        .level  (run_level),
        .press  (run_press)
    );

    assign unused_levels = step_level ^ run_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_STOPPED;
            prescale_cnt <= '0;
            enable       <= 1'b0;
            running      <= 1'b0;
        end else begin
            state        <= state_next;
            prescale_cnt <= prescale_next;
            enable       <= enable_next;
            running      <= (state_next == ST_RUNNING);
        end
    end

    // A run press always takes priority, so a simultaneous step press is dropped.
    always_comb begin
        state_next    = state;
        prescale_next = prescale_cnt;
        enable_next   = 1'b0;
        case (state)
            ST_STOPPED: begin
                if (run_press) begin
                    state_next    = ST_RUNNING;
                    prescale_next = '0;
                end else if (step_press) begin
                    enable_next = 1'b1;
                end
            end
            ST_RUNNING: begin
                if (run_press) begin
                    state_next    = ST_STOPPED;
                    prescale_next = '0;
                end else if (prescale_cnt == PS_LAST) begin
                    prescale_next = '0;
                    enable_next   = 1'b1;
                end else begin
                    prescale_next = prescale_cnt + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_count_enable_gen.sv
// tb/tb_count_enable_gen.sv - directed self-checking bench for count_enable_gen
module tb_count_enable_gen;

    logic clk;
    logic reset;
    logic btn_step;
    logic btn_run;
    logic enable;
    logic running;

    int n_checks;
    int n_pass;

    count_enable_gen #(
        .DEBOUNCE_CYCLES(4),
        .PRESCALE       (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_step(btn_step),
        .btn_run (btn_run),
        .enable  (enable),
        .running (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input logic en_exp, input logic run_exp, input string tag, input int k);
        n_checks++;
        assert (enable === en_exp && running === run_exp) n_pass++;
        else $error("FAIL %s edge %0d: enable=%b running=%b expected enable=%b running=%b",
                    tag, k, enable, running, en_exp, run_exp);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        btn_step = 1'b0;
        btn_run  = 1'b0;

        // 1: reset and idle
        for (int k = 1; k <= 2; k++) begin
            tick();
            chk(1'b0, 1'b0, "reset", k);
        end
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk(1'b0, 1'b0, "idle", k);
        end

        // 2: single step press, pulse at edge 7, nothing on release
        btn_step = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 10) btn_step = 1'b0;
            chk((k == 7), 1'b0, "step_press", k);
        end

        // 3: bouncing step button never passes the filter
        for (int k = 0; k < 12; k++) begin
            btn_step = ((k / 2) % 2 == 0);
            tick();
            chk(1'b0, 1'b0, "bounce", k + 1);
        end
        btn_step = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk(1'b0, 1'b0, "bounce_idle", k);
        end

        // 4: run press, free-run pulses every 8 edges
        btn_run = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 10) btn_run = 1'b0;
            chk((k == 15 || k == 23 || k == 31), (k >= 7), "run_start", k);
        end
        // second press lands on the edge where the prescaler would wrap: no pulse
        btn_run = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 10) btn_run = 1'b0;
            chk(1'b0, (k < 7), "run_stop", k);
        end

        // 5: simultaneous press, then a step press while running is ignored
        btn_step = 1'b1;
        btn_run  = 1'b1;
        for (int k = 1; k <= 41; k++) begin
            tick();
            if (k == 10) begin
                btn_step = 1'b0;
                btn_run  = 1'b0;
            end
            if (k == 12) btn_step = 1'b1;
            if (k == 22) btn_step = 1'b0;
            chk((k == 15 || k == 23 || k == 31 || k == 39), (k >= 7), "both_press", k);
        end

        // 6: reset three edges after a running pulse
        reset = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            chk(1'b0, 1'b0, "mid_reset", k);
        end
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk(1'b0, 1'b0, "post_reset", k);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
